// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and sizing helper for the iterative Booth multiplier
//
// Purpose: operation, Booth-digit selection and FSM state encodings, plus the
//          digit-count function used to size the multiplier datapath.
// Ports:   none (package).
// Option:  BOOTH_MUL_ZERO_SKIP_EN is consumed by booth_mul_iter, not here.

package booth_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_sel_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Radix-4 digits needed for a WIDTH+2 bit multiplier, padded up so every
    // BUSY cycle retires a full group of dpc digits.
    function automatic int n_dig(input int width, input int dpc);
        int n;
        n = (width + 3) / 2;
        return ((n + dpc - 1) / dpc) * dpc;
    endfunction

endpackage

// File: rtl/booth_digit_step.sv
// rtl/booth_digit_step.sv - one combinational radix-4 Booth digit: select, add, shift
//
// Purpose: decodes three multiplier bits into 0/+A/+2A/-A/-2A, adds that into
//          the upper field of the partial sum (starting at bit LSB) and
//          arithmetic-shifts the result right by two.
// Ports:
//   bits      in  3               multiplier bits {b[2k+1], b[2k], b[2k-1]}
//   mcand     in  WIDTH+2         sign/zero-extended multiplicand
//   psum      in  LSB+WIDTH+4     partial sum before this digit
//   next_sum  out LSB+WIDTH+4     partial sum after add and shift

module booth_digit_step
    import booth_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LSB   = 34
) (
    input  logic [2:0]             bits,
    input  logic [WIDTH+1:0]       mcand,
    input  logic [LSB+WIDTH+3:0]   psum,
    output logic [LSB+WIDTH+3:0]   next_sum
);

    // Upper field is two bits wider than the multiplicand so that 2A and the
    // running sum never overflow before the shift.
    localparam int HW = WIDTH + 4;

    booth_sel_e        sel;
    logic              neg;
    logic [HW-1:0]     m1;
    logic [HW-1:0]     m2;
    logic [HW-1:0]     mag;
    logic [HW-1:0]     addend;
    logic [HW-1:0]     hi;
    logic [LSB+HW-1:0] sum;

    assign m1 = {{2{mcand[WIDTH+1]}}, mcand};
    assign m2 = {m1[HW-2:0], 1'b0};

    always_comb begin
        sel = ZERO;
        unique case (bits)
            3'b001, 3'b010: sel = POS1;
            3'b011:         sel = POS2;
            3'b100:         sel = NEG2;
            3'b101, 3'b110: sel = NEG1;
            default:        sel = ZERO;
        endcase
    end

    always_comb begin
        neg = (sel == NEG1) || (sel == NEG2);
        unique case (sel)
            POS1, NEG1: mag = m1;
            POS2, NEG2: mag = m2;
            default:    mag = '0;
        endcase
        // Negation is one's complement here plus a carry-in below.
        addend = neg ? ~mag : mag;
        hi     = psum[LSB+HW-1:LSB] + addend + {{(HW-1){1'b0}}, neg};
    end

    assign sum      = {hi, psum[LSB-1:0]};
    assign next_sum = $signed(sum) >>> 2;

endmodule

// File: rtl/booth_mul_iter.sv
// rtl/booth_mul_iter.sv - iterative radix-4 Booth multiplier for RV32M MUL/MULH/MULHSU/MULHU
//
// Purpose: accepts one operation at a time, retires DIGITS_PER_CYCLE Booth
//          digits per BUSY cycle and holds the result until it is taken.
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_valid / o_ready       request handshake (o_ready only in IDLE)
//   i_op                    00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   i_data_a, i_data_b      multiplicand (rs1), multiplier (rs2)
//   o_valid / i_ready       result handshake (o_valid only in DONE)
//   o_data                  MUL: low half of product, others: high half
//   o_product               full 2*WIDTH product
// Option: BOOTH_MUL_ZERO_SKIP_EN - a zero operand finishes after a single edge.

module booth_mul_iter
    import booth_pkg::*;
#(
    parameter int WIDTH            = 32,
    parameter int DIGITS_PER_CYCLE = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [1:0]         i_op,
    input  logic [WIDTH-1:0]   i_data_a,
    input  logic [WIDTH-1:0]   i_data_b,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [WIDTH-1:0]   o_data,
    output logic [2*WIDTH-1:0] o_product
);

    localparam int N_DIG  = n_dig(WIDTH, DIGITS_PER_CYCLE);
    localparam int CYCLES = N_DIG / DIGITS_PER_CYCLE;
    localparam int LSB    = 2 * N_DIG;
    localparam int ACC_W  = LSB + WIDTH + 4;
    localparam int BW     = LSB + 1;
    localparam int SHIFT  = 2 * DIGITS_PER_CYCLE;
    localparam int CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    state_e           state;
    mul_op_e          op_q;
    mul_op_e          op_in;
    logic [WIDTH+1:0] a_q;
    // Multiplier shift register; bit 0 carries the b[2k-1] bit of the next digit.
    logic [BW-1:0]    b_q;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic             a_sgn;
    logic             b_sgn;
    logic [WIDTH+1:0] a_ext;
    logic [LSB-1:0]   b_ext;
    logic [CNT_W-1:0] cnt_init;

    assign op_in = mul_op_e'(i_op);

    always_comb begin
        a_sgn = (op_in != MULHU);
        b_sgn = (op_in == MUL) || (op_in == MULH);
        a_ext = {{2{a_sgn & i_data_a[WIDTH-1]}}, i_data_a};
        b_ext = {{(LSB-WIDTH){b_sgn & i_data_b[WIDTH-1]}}, i_data_b};
`ifdef BOOTH_MUL_ZERO_SKIP_EN
        // A zero operand makes every digit contribute nothing, so one BUSY
        // edge already yields the exact (zero) product.
        if ((i_data_a == '0) || (i_data_b == '0)) begin
            cnt_init = '0;
        end else begin
            cnt_init = CNT_W'(CYCLES - 1);
        end
`else
        cnt_init = CNT_W'(CYCLES - 1);
`endif
    end

    // Digit chain for one BUSY cycle: stage j consumes b_q[2j+2:2j].
    logic [ACC_W-1:0] chain [DIGITS_PER_CYCLE+1];

    assign chain[0] = acc;

    for (genvar j = 0; j < DIGITS_PER_CYCLE; j++) begin : g_step
        booth_digit_step #(
            .WIDTH (WIDTH),
            .LSB   (LSB)
        ) u_step (
            .bits     (b_q[2*j+2:2*j]),
            .mcand    (a_q),
            .psum     (chain[j]),
            .next_sum (chain[j+1])
        );
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            op_q      <= MUL;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            cnt       <= '0;
            o_ready   <= 1'b1;
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_product <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_valid) begin
                        op_q    <= op_in;
                        a_q     <= a_ext;
                        b_q     <= {b_ext, 1'b0};
                        acc     <= '0;
                        cnt     <= cnt_init;
                        o_ready <= 1'b0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    acc <= chain[DIGITS_PER_CYCLE];
                    b_q <= $signed(b_q) >>> SHIFT;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state     <= DONE;
                        o_valid   <= 1'b1;
                        o_product <= chain[DIGITS_PER_CYCLE][2*WIDTH-1:0];
                        o_data    <= (op_q == MUL) ? chain[DIGITS_PER_CYCLE][WIDTH-1:0]
                                                   : chain[DIGITS_PER_CYCLE][2*WIDTH-1:WIDTH];
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state   <= IDLE;
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
